centroid_tracker: RTL and testbench

//  Sits directly downstream of difference_engine. Snoops its per-pixel binary-diff write stream and sums x, y and
//  the count of set pixels over each frame. At frame end it divides the sums to get the motion centroid, smooths it
//  and hands {x,y} to display/draw_history over a valid/ready handshake. This removes the in-display accumulation.

---
 rtl/motion_pkg.sv | 54 +++++
 rtl/centroid_tracker_if.sv | 48 ++++
 rtl/seq_divider.sv | 77 +++++++
 rtl/centroid_tracker.sv | 205 ++++++++++++++++++++
 tb/tb_centroid_tracker.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared constants for the motion pipeline: image geometry, pixel coordinate
// widths, accumulator widths, motion threshold, smoothing weights and the
// centroid_tracker FSM state encodings.
//
// Optional feature macro: CENTROID_SMOOTHING_EN.
// When it is defined, the package also provides smooth_mix(), the IIR blend
// of the previous centroid with the new quotient.
// -----------------------------------------------------------------------------
package motion_pkg;

  localparam int X_WIDTH              = 9;
  localparam int Y_WIDTH              = 8;
  localparam int IMAGE_W              = 320;
  localparam int IMAGE_H              = 240;
  localparam int DIFFERENCE_THRESHOLD = 400;

  // 320*240*319 < 2^25 and 76800 < 2^17, so a full frame cannot overflow.
  localparam int ACC_WIDTH = 25;
  localparam int CNT_WIDTH = 17;

  // Smoothing weights. W_OLD + W_NEW must be 16 so the blend is a plain >>4.
  localparam int W_OLD    = 10;
  localparam int W_NEW    = 6;
  localparam int SMOOTH_W = 13;

  // FSM state encodings.
  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_DIVIDE  = 2'd1;
  localparam logic [1:0] ST_SMOOTH  = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  // One frame's worth of accumulated statistics.
  typedef struct packed {
    logic [ACC_WIDTH-1:0] x_sum;
    logic [ACC_WIDTH-1:0] y_sum;
    logic [CNT_WIDTH-1:0] cnt;
  } acc_t;

`ifdef CENTROID_SMOOTHING_EN
  // (old*W_OLD + new*W_NEW) >> 4, evaluated in SMOOTH_W bits and truncated.
  // With coordinates below 320 the largest sum is 319*16 = 5104, which fits.
  function automatic logic [SMOOTH_W-1:0] smooth_mix(
    input logic [SMOOTH_W-1:0] old_v,
    input logic [SMOOTH_W-1:0] new_v
  );
    logic [SMOOTH_W-1:0] sum_v;
    sum_v = (old_v * SMOOTH_W'(W_OLD)) + (new_v * SMOOTH_W'(W_NEW));
    return sum_v >> 4;
  endfunction
`endif

endpackage

// File: rtl/centroid_tracker_if.sv
// -----------------------------------------------------------------------------
// centroid_tracker_if
// Bundles the diff-pixel snoop stream and the centroid result handshake.
//
//   pix_en, pix_diff     diff pixel write strobe and diff bit
//   pix_x, pix_y         pixel column / row
//   frame_end            one-cycle pulse on the last pixel of a frame
//   centroid_x/y         smoothed centroid
//   motion_detected      last presented frame reached the motion threshold
//   centroid_valid       result available, held until accepted
//   centroid_ready       consumer ready
//   frame_dropped        one-cycle pulse, a frame result was discarded
//
// Handshake: centroid_valid rises when a result is available and then stays
// high, with centroid_x/y and motion_detected held stable, until the consumer
// has centroid_ready high on a rising clock edge. That edge is the transfer,
// and valid is low after it. Ready may be high at any time and has no effect
// while valid is low.
//
// master: the producer/consumer side (drives pixels, frame_end, ready).
// slave : centroid_tracker.
// -----------------------------------------------------------------------------
interface centroid_tracker_if;

  logic                            pix_en;
  logic                            pix_diff;
  logic [motion_pkg::X_WIDTH-1:0]  pix_x;
  logic [motion_pkg::Y_WIDTH-1:0]  pix_y;
  logic                            frame_end;

  logic [motion_pkg::X_WIDTH-1:0]  centroid_x;
  logic [motion_pkg::Y_WIDTH-1:0]  centroid_y;
  logic                            motion_detected;
  logic                            centroid_valid;
  logic                            centroid_ready;
  logic                            frame_dropped;

  modport master (
    output pix_en, pix_diff, pix_x, pix_y, frame_end, centroid_ready,
    input  centroid_x, centroid_y, motion_detected, centroid_valid, frame_dropped
  );

  modport slave (
    input  pix_en, pix_diff, pix_x, pix_y, frame_end, centroid_ready,
    output centroid_x, centroid_y, motion_detected, centroid_valid, frame_dropped
  );

endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock, DIVIDEND_W clocks.
//
//   clock, resetn  clock and synchronous active-low reset (aborts a divide)
//   i_start        load operands; iterations run on the following edges
//   i_dividend     dividend, DIVIDEND_W bits
//   i_divisor      divisor, DIVISOR_W bits (must be non-zero)
//   o_busy         iterations in progress
//   o_done         high during the final iteration; o_quotient holds the
//                  complete result from the next cycle on
//   o_quotient     quotient, DIVIDEND_W bits
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DIVIDEND_W = 25,
  parameter int DIVISOR_W  = 17
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DIVIDEND_W-1:0] o_quotient
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  // r_quo starts as the dividend; each iteration shifts one dividend bit out
  // of the top and one quotient bit in at the bottom.
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;

  logic [DIVISOR_W:0]    w_trial;
  logic [DIVISOR_W-1:0]  w_diff;
  logic                  w_fits;

  // The remainder is always below the divisor, so the trial value fits in
  // DIVISOR_W+1 bits and trial-divisor fits back into DIVISOR_W bits.
  always_comb begin
    w_trial = {r_rem, r_quo[DIVIDEND_W-1]};
    w_fits  = (w_trial >= {1'b0, r_dvs});
    w_diff  = w_trial[DIVISOR_W-1:0] - r_dvs;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_cnt  <= CW'(DIVIDEND_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_fits ? w_diff : w_trial[DIVISOR_W-1:0];
      r_quo <= {r_quo[DIVIDEND_W-2:0], w_fits};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == CW'(1));
  assign o_quotient = r_quo;

endmodule

// File: rtl/centroid_tracker.sv
// -----------------------------------------------------------------------------
// centroid_tracker
// Snoops the binary-diff pixel write stream, sums x, y and the number of set
// pixels over each frame, divides at frame end to get the motion centroid,
// optionally smooths it, and presents {x,y} over a valid/ready handshake.
//
//   clock      single clock
//   resetn     synchronous active-low reset; aborts any divide in progress
//   io_bus     centroid_tracker_if.slave: pixel stream in, result out
//   o_state    current FSM state (ST_ACCUM/DIVIDE/SMOOTH/PRESENT)
//
// Optional feature macro: CENTROID_SMOOTHING_EN.
//   defined   : SMOOTH blends old and new, (old*W_OLD + q*W_NEW) >> 4
//   undefined : SMOOTH loads the raw quotients, no multipliers
//
// Result timing from the edge that samples frame_end in ST_ACCUM:
//   motion frame    : valid high after ACC_WIDTH+2 edges
//   no-motion frame : valid high after 3 edges
// -----------------------------------------------------------------------------
module centroid_tracker
  import motion_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  centroid_tracker_if.slave io_bus,
  output logic [1:0]        o_state
);

  logic [1:0]           r_state;
  logic [ACC_WIDTH-1:0] r_x_sum;
  logic [ACC_WIDTH-1:0] r_y_sum;
  logic [CNT_WIDTH-1:0] r_cnt;
  acc_t                 r_snap;
  logic                 r_div_started;
  logic                 r_frame_motion;
  logic                 r_motion;
  logic                 r_drop;
  logic [X_WIDTH-1:0]   r_cx;
  logic [Y_WIDTH-1:0]   r_cy;

  logic                 w_hit;
  acc_t                 w_acc_next;
  logic                 w_enough;
  logic                 w_div_start;
  logic                 w_done_x;
  logic                 w_done_y;
  logic                 w_busy_x;
  logic                 w_busy_y;
  logic [ACC_WIDTH-1:0] w_qx;
  logic [ACC_WIDTH-1:0] w_qy;
  logic [X_WIDTH-1:0]   w_new_x;
  logic [Y_WIDTH-1:0]   w_new_y;
  logic                 w_unused_bits;

  // ---------------------------------------------------------------------------
  // Accumulation runs in every state. w_acc_next already includes the pixel of
  // the current cycle, so a pixel arriving with frame_end lands in the
  // snapshot of the frame it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_hit = io_bus.pix_en && io_bus.pix_diff &&
            (io_bus.pix_x < X_WIDTH'(IMAGE_W)) &&
            (io_bus.pix_y < Y_WIDTH'(IMAGE_H));
    w_acc_next.x_sum = r_x_sum + (w_hit ? ACC_WIDTH'(io_bus.pix_x) : '0);
    w_acc_next.y_sum = r_y_sum + (w_hit ? ACC_WIDTH'(io_bus.pix_y) : '0);
    w_acc_next.cnt   = r_cnt   + (w_hit ? CNT_WIDTH'(1) : '0);
  end

  // Every frame_end starts a fresh frame, even when its result is dropped.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_x_sum <= '0;
      r_y_sum <= '0;
      r_cnt   <= '0;
    end else if (io_bus.frame_end) begin
      r_x_sum <= '0;
      r_y_sum <= '0;
      r_cnt   <= '0;
    end else begin
      r_x_sum <= w_acc_next.x_sum;
      r_y_sum <= w_acc_next.y_sum;
      r_cnt   <= w_acc_next.cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Dividers. A frame below the threshold never starts them, which also keeps
  // a zero count away from the divisor.
  // ---------------------------------------------------------------------------
  assign w_enough    = (r_snap.cnt >= CNT_WIDTH'(DIFFERENCE_THRESHOLD));
  assign w_div_start = (r_state == ST_DIVIDE) && !r_div_started && w_enough;

  seq_divider #(
    .DIVIDEND_W (ACC_WIDTH),
    .DIVISOR_W  (CNT_WIDTH)
  ) u_div_x (
    .clock      (clock),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_dividend (r_snap.x_sum),
    .i_divisor  (r_snap.cnt),
    .o_busy     (w_busy_x),
    .o_done     (w_done_x),
    .o_quotient (w_qx)
  );

  seq_divider #(
    .DIVIDEND_W (ACC_WIDTH),
    .DIVISOR_W  (CNT_WIDTH)
  ) u_div_y (
    .clock      (clock),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_dividend (r_snap.y_sum),
    .i_divisor  (r_snap.cnt),
    .o_busy     (w_busy_y),
    .o_done     (w_done_y),
    .o_quotient (w_qy)
  );

  // ---------------------------------------------------------------------------
  // New centroid value loaded in SMOOTH. Quotients of in-range pixels are
  // below the image size, so only the coordinate-width low bits matter.
  // ---------------------------------------------------------------------------
`ifdef CENTROID_SMOOTHING_EN
  logic [SMOOTH_W-1:0] w_mix_x;
  logic [SMOOTH_W-1:0] w_mix_y;

  assign w_mix_x = smooth_mix(SMOOTH_W'(r_cx), SMOOTH_W'(w_qx[X_WIDTH-1:0]));
  assign w_mix_y = smooth_mix(SMOOTH_W'(r_cy), SMOOTH_W'(w_qy[Y_WIDTH-1:0]));
  assign w_new_x = w_mix_x[X_WIDTH-1:0];
  assign w_new_y = w_mix_y[Y_WIDTH-1:0];
  assign w_unused_bits = ^{w_qx[ACC_WIDTH-1:X_WIDTH], w_qy[ACC_WIDTH-1:Y_WIDTH],
                           w_busy_x, w_busy_y,
                           w_mix_x[SMOOTH_W-1:X_WIDTH], w_mix_y[SMOOTH_W-1:Y_WIDTH]};
`else
  assign w_new_x = w_qx[X_WIDTH-1:0];
  assign w_new_y = w_qy[Y_WIDTH-1:0];
  assign w_unused_bits = ^{w_qx[ACC_WIDTH-1:X_WIDTH], w_qy[ACC_WIDTH-1:Y_WIDTH],
                           w_busy_x, w_busy_y};
`endif

  // ---------------------------------------------------------------------------
  // FSM: ACCUM -> DIVIDE -> SMOOTH -> PRESENT -> ACCUM.
  // The first DIVIDE cycle latches the motion decision and starts the
  // dividers; the state then waits for the final divider iteration, or leaves
  // on the next cycle when the frame is below the threshold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state        <= ST_ACCUM;
      r_snap         <= '0;
      r_div_started  <= 1'b0;
      r_frame_motion <= 1'b0;
      r_motion       <= 1'b0;
      r_drop         <= 1'b0;
      r_cx           <= X_WIDTH'(IMAGE_W / 2);
      r_cy           <= Y_WIDTH'(IMAGE_H / 2);
    end else begin
      // A frame ending while a result is still in flight or unaccepted is
      // discarded; the in-flight result is left alone.
      r_drop <= io_bus.frame_end && (r_state != ST_ACCUM);

      case (r_state)
        ST_ACCUM: begin
          if (io_bus.frame_end) begin
            r_snap        <= w_acc_next;
            r_div_started <= 1'b0;
            r_state       <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (!r_div_started) begin
            r_div_started  <= 1'b1;
            r_frame_motion <= w_enough;
          end else if (!r_frame_motion || (w_done_x && w_done_y)) begin
            r_state <= ST_SMOOTH;
          end
        end
        ST_SMOOTH: begin
          if (r_frame_motion) begin
            r_cx <= w_new_x;
            r_cy <= w_new_y;
          end
          r_motion <= r_frame_motion;
          r_state  <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (io_bus.centroid_ready) begin
            r_state <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign io_bus.centroid_x      = r_cx;
  assign io_bus.centroid_y      = r_cy;
  assign io_bus.motion_detected = r_motion;
  assign io_bus.centroid_valid  = (r_state == ST_PRESENT);
  assign io_bus.frame_dropped   = r_drop;
  assign o_state                = r_state;

endmodule

// File: tb/tb_centroid_tracker.sv
// -----------------------------------------------------------------------------
// tb_centroid_tracker
// Directed bench for centroid_tracker. A frame-level model tracks the pixel
// sums with plain integers, computes each frame's expected result at
// frame_end and releases it when valid is due; a negedge compare process
// checks the DUT against it every cycle. Literal expectations from the hand
// calculations pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_centroid_tracker;

  // ---------------------------------------------------------------- clock/reset
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  centroid_tracker_if u_if ();
  logic [1:0] dbg_state;

  centroid_tracker dut (
    .clock   (clock),
    .resetn  (resetn),
    .io_bus  (u_if),
    .o_state (dbg_state)
  );

`ifdef CENTROID_SMOOTHING_EN
  localparam int T1_X = 140;
  localparam int T1_Y = 97;
  localparam int T5_X = 140;
  localparam int T5_Y = 96;
`else
  localparam int T1_X = 109;
  localparam int T1_Y = 59;
  localparam int T5_X = 109;
  localparam int T5_Y = 59;
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [17:0] exp_q[$];   // {motion, x[8:0], y[7:0]} per accepted frame
  int m_x, m_y, m_cd;
  int xs, ys, ns;
  bit m_motion, m_valid, m_drop, m_busy, m_live;

  always @(posedge clock) begin
    bit          was_busy;
    bit          hit;
    int          qx, qy, nx, ny;
    logic [17:0] r;
    if (!resetn) begin
      m_live = 1; m_x = 160; m_y = 120; m_motion = 0; m_valid = 0;
      m_drop = 0; m_busy = 0; m_cd = 0; xs = 0; ys = 0; ns = 0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      m_drop   = (u_if.frame_end === 1'b1) && was_busy;
      hit = (u_if.pix_en === 1'b1) && (u_if.pix_diff === 1'b1) &&
            (u_if.pix_x < 320) && (u_if.pix_y < 240);
      if (hit) begin
        xs += int'(u_if.pix_x); ys += int'(u_if.pix_y); ns += 1;
      end
      if (m_valid && u_if.centroid_ready === 1'b1) begin
        m_valid = 0; m_busy = 0;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0 && exp_q.size() > 0) begin
          r = exp_q.pop_front();
          m_motion = r[17]; m_x = int'(r[16:8]); m_y = int'(r[7:0]); m_valid = 1;
        end
      end
      if (u_if.frame_end === 1'b1) begin
        if (!was_busy) begin
          if (ns >= 400) begin
            qx = xs / ns; qy = ys / ns;
`ifdef CENTROID_SMOOTHING_EN
            nx = (m_x * 10 + qx * 6) / 16;
            ny = (m_y * 10 + qy * 6) / 16;
`else
            nx = qx; ny = qy;
`endif
            exp_q.push_back({1'b1, 9'(nx), 8'(ny)});
            m_cd = 27;
          end else begin
            exp_q.push_back({1'b0, 9'(m_x), 8'(m_y)});
            m_cd = 3;
          end
          m_busy = 1;
        end
        xs = 0; ys = 0; ns = 0;
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clock) begin
    if (m_live) begin
      check("valid", u_if.centroid_valid, m_valid);
      check("frame_dropped", u_if.frame_dropped, m_drop);
      if (!m_busy || m_valid) begin
        check("centroid_x", u_if.centroid_x, m_x);
        check("centroid_y", u_if.centroid_y, m_y);
        check("motion", u_if.motion_detected, m_motion);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic pixel(input int x, input int y, input bit diff, input bit en);
    u_if.pix_en = en; u_if.pix_diff = diff;
    u_if.pix_x = 9'(x); u_if.pix_y = 8'(y);
    tick();
    u_if.pix_en = 1'b0; u_if.pix_diff = 1'b0;
  endtask

  // n diff pixels in raster order over a w x h block at (x0,y0)
  task automatic send_block(input int x0, input int y0, input int w, input int n);
    for (int i = 0; i < n; i++) begin
      u_if.pix_en = 1'b1; u_if.pix_diff = 1'b1;
      u_if.pix_x = 9'(x0 + i % w); u_if.pix_y = 8'(y0 + i / w);
      tick();
    end
    u_if.pix_en = 1'b0; u_if.pix_diff = 1'b0;
  endtask

  task automatic frame_and_wait(input bit add_pix, input int px, input int py,
                                input int exp_lat, input string name);
    int lat;
    u_if.pix_en = add_pix; u_if.pix_diff = add_pix;
    u_if.pix_x = 9'(px); u_if.pix_y = 8'(py);
    u_if.frame_end = 1'b1;
    tick();
    u_if.frame_end = 1'b0; u_if.pix_en = 1'b0; u_if.pix_diff = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (u_if.centroid_valid !== 1'b1 && lat < 100);
    check(name, lat, exp_lat);
  endtask

  task automatic accept();
    u_if.centroid_ready = 1'b1;
    tick();
    u_if.centroid_ready = 1'b0;
    check("valid_after_accept", u_if.centroid_valid, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    u_if.pix_en = 1'b0; u_if.pix_diff = 1'b0; u_if.pix_x = '0; u_if.pix_y = '0;
    u_if.frame_end = 1'b0; u_if.centroid_ready = 1'b0;

    apply_reset();
    check("reset_x", u_if.centroid_x, 160);
    check("reset_y", u_if.centroid_y, 120);
    check("reset_valid", u_if.centroid_valid, 0);
    check("reset_motion", u_if.motion_detected, 0);
    check("reset_dropped", u_if.frame_dropped, 0);

    // 1: 400 diffs over x100..119, y50..69
    send_block(100, 50, 20, 400);
    frame_and_wait(1'b0, 0, 0, 27, "t1_latency");
    check("t1_x", u_if.centroid_x, T1_X);
    check("t1_y", u_if.centroid_y, T1_Y);
    check("t1_motion", u_if.motion_detected, 1);
    accept();

    // 2: 399 diffs, below threshold
    apply_reset();
    send_block(100, 50, 20, 399);
    frame_and_wait(1'b0, 0, 0, 3, "t2_latency");
    check("t2_x", u_if.centroid_x, 160);
    check("t2_y", u_if.centroid_y, 120);
    check("t2_motion", u_if.motion_detected, 0);
    accept();

    // 3: 400th pixel arrives with frame_end
    send_block(100, 50, 20, 399);
    frame_and_wait(1'b1, 119, 69, 27, "t3_latency");
    check("t3_motion", u_if.motion_detected, 1);
    accept();
    // next frame starts from zero; out-of-range and non-diff pixels ignored
    send_block(100, 50, 20, 399);
    pixel(320, 10, 1'b1, 1'b1);
    pixel(10, 240, 1'b1, 1'b1);
    pixel(5, 5, 1'b0, 1'b1);
    pixel(6, 6, 1'b1, 1'b0);
    frame_and_wait(1'b0, 0, 0, 3, "t3b_latency");
    check("t3b_motion", u_if.motion_detected, 0);
    accept();

    // 4: full frame of diffs
    apply_reset();
    send_block(0, 0, 320, 76800);
    frame_and_wait(1'b0, 0, 0, 27, "t4_latency");
    check("t4_x", u_if.centroid_x, 159);
    check("t4_y", u_if.centroid_y, 119);
    accept();

    // 5: backpressure and a dropped frame
    send_block(100, 50, 20, 400);
    frame_and_wait(1'b0, 0, 0, 27, "t5_latency");
    tick();
    tick();
    check("t5_valid_held", u_if.centroid_valid, 1);
    send_block(100, 50, 20, 300);
    u_if.frame_end = 1'b1;
    tick();
    u_if.frame_end = 1'b0;
    check("t5_drop_pulse", u_if.frame_dropped, 1);
    check("t5_x_held", u_if.centroid_x, T5_X);
    check("t5_y_held", u_if.centroid_y, T5_Y);
    tick();
    check("t5_drop_end", u_if.frame_dropped, 0);
    check("t5_valid_still", u_if.centroid_valid, 1);
    accept();
    send_block(100, 50, 20, 300);
    frame_and_wait(1'b0, 0, 0, 3, "t5b_latency");
    check("t5b_motion", u_if.motion_detected, 0);
    accept();

    // 6: reset in the middle of a divide
    apply_reset();
    send_block(100, 50, 20, 400);
    u_if.frame_end = 1'b1;
    tick();
    u_if.frame_end = 1'b0;
    repeat (10) tick();
    resetn = 1'b0;
    tick();
    check("t6_valid", u_if.centroid_valid, 0);
    check("t6_x", u_if.centroid_x, 160);
    check("t6_y", u_if.centroid_y, 120);
    resetn = 1'b1;
    send_block(100, 50, 20, 400);
    frame_and_wait(1'b0, 0, 0, 27, "t6_latency");
    check("t6b_x", u_if.centroid_x, T1_X);
    check("t6b_y", u_if.centroid_y, T1_Y);
    accept();

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
